// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags.
// Single-cycle base and rotate/shift ops, WIDTH-cycle shift-add multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cy_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       SZCy,
    output logic             ov,
    output logic             op_err
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_mulh;

    logic             w_accept;
    logic [WIDTH:0]   w_wide;
    logic             w_ov;
    logic             w_err;
    logic             w_is_mul;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic [WIDTH-1:0] w_mres;
    logic             w_mcy;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_HOLD);

    // Single-cycle ops: WIDTH+1 wide result, carry/borrow in the top bit
    always_comb begin
        w_wide   = '0;
        w_ov     = 1'b0;
        w_err    = 1'b0;
        w_is_mul = 1'b0;
        case (aluop)
            5'b00000: w_wide = {1'b0, a};
            5'b00001: w_wide = {1'b0, b};
            5'b00010: w_wide = {1'b0, ~a};
            5'b00011: w_wide = {1'b0, ~b};
            5'b00100: w_wide = {1'b0, a & b};
            5'b00101: w_wide = {1'b0, a | b};
            5'b00110: w_wide = {1'b0, a ^ b};
            5'b00111: w_wide = '0;
            5'b01000: begin
                w_wide = {1'b0, a} + W1'(1);
                w_ov   = ~a[WIDTH-1] & w_wide[WIDTH-1];
            end
            5'b01001: begin
                w_wide = {1'b0, a} - W1'(1);
                w_ov   = a[WIDTH-1] & ~w_wide[WIDTH-1];
            end
            5'b01010: begin
                w_wide = {1'b0, a} + {1'b0, b};
                w_ov   = (a[WIDTH-1] == b[WIDTH-1]) & (w_wide[WIDTH-1] != a[WIDTH-1]);
            end
            5'b01011: begin
                w_wide = {1'b0, a} - {1'b0, b};
                w_ov   = (a[WIDTH-1] != b[WIDTH-1]) & (w_wide[WIDTH-1] != a[WIDTH-1]);
            end
            5'b01100: begin
                w_wide = {1'b0, a} + {1'b0, b} + W1'(Cy_in);
                w_ov   = (a[WIDTH-1] == b[WIDTH-1]) & (w_wide[WIDTH-1] != a[WIDTH-1]);
            end
            5'b01101: begin
                w_wide = {1'b0, a} - {1'b0, b} - W1'(Cy_in);
                w_ov   = (a[WIDTH-1] != b[WIDTH-1]) & (w_wide[WIDTH-1] != a[WIDTH-1]);
            end
            5'b01110: w_wide = {a, 1'b0};
            5'b01111: w_wide = {a[0], 1'b0, a[WIDTH-1:1]};
            5'b10000: w_is_mul = 1'b1;
            5'b10001: w_is_mul = 1'b1;
            5'b10010: w_wide = {a[WIDTH-1], a[WIDTH-2:0], Cy_in};
            5'b10011: w_wide = {a[0], Cy_in, a[WIDTH-1:1]};
            5'b10100: w_wide = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
            default:  w_err = 1'b1;
        endcase
    end

    // One shift-add multiply step: conditional add into high half, then shift right
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : W1'(0));
        w_hi_nx = w_sum[WIDTH:1];
        w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
        w_mres  = r_mulh ? w_hi_nx : w_lo_nx;
        w_mcy   = ~r_mulh & (|w_hi_nx);
    end

    // Control FSM, multiply datapath and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mulh  <= 1'b0;
            result  <= '0;
            SZCy    <= 3'b000;
            ov      <= 1'b0;
            op_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                            r_cnt   <= CW'(WIDTH - 1);
                            r_mcand <= a;
                            r_hi    <= '0;
                            r_lo    <= b;
                            r_mulh  <= aluop[0];
                        end else begin
                            r_state <= S_HOLD;
                            result  <= w_wide[WIDTH-1:0];
                            SZCy    <= {w_wide[WIDTH-1], (w_wide[WIDTH-1:0] == '0), w_wide[WIDTH]};
                            ov      <= w_ov;
                            op_err  <= w_err;
                        end
                    end else if (r_state == S_HOLD && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        result  <= w_mres;
                        SZCy    <= {w_mres[WIDTH-1], (w_mres == '0), w_mcy};
                        ov      <= 1'b0;
                        op_err  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
